// File: rtl/mac_feeder_pkg.sv
// Shared types and widths for the MAC operand feeder.
// Optional build macro: MAC_FEEDER_STATS_EN adds a res_terms output to the feeder.
package mac_feeder_pkg;

    localparam int unsigned OP_W  = 16;
    localparam int unsigned ACC_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN,
        HOLD,
        CLEAR
    } feeder_state_t;

    typedef struct packed {
        logic            last;
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Operand stream, MAC side and result handshake of the operand feeder.
// Optional build macro: MAC_FEEDER_STATS_EN adds res_terms.
interface mac_operand_feeder_if;
    import mac_feeder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             in_last;
    logic [OP_W-1:0]  mac_a;
    logic [OP_W-1:0]  mac_b;
    logic             mac_clr;
    logic [ACC_W-1:0] mac_out;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
`ifdef MAC_FEEDER_STATS_EN
    logic [15:0]      res_terms;
`endif

    // Feeder side.
    modport slave (
        input  in_valid, in_a, in_b, in_last, mac_out, res_ready,
`ifdef MAC_FEEDER_STATS_EN
        output res_terms,
`endif
        output in_ready, mac_a, mac_b, mac_clr, res_valid, res_data
    );

    // Environment side: operand source, MAC and result consumer.
    modport master (
        output in_valid, in_a, in_b, in_last, mac_out, res_ready,
`ifdef MAC_FEEDER_STATS_EN
        input  res_terms,
`endif
        input  in_ready, mac_a, mac_b, mac_clr, res_valid, res_data
    );

endinterface

// File: rtl/mac_feeder_fifo.sv
// Synchronous FIFO of operand pairs with registered pointers and full/empty flags.
module mac_feeder_fifo
    import mac_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  op_pair_t i_wdata,
    input  logic     i_pop,
    output op_pair_t o_rdata,
    output logic     o_full,
    output logic     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit separates full from empty when the indices match.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    op_pair_t    r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/mac_operand_feeder.sv
// Streams buffered operand pairs onto the MAC, then captures and clears the accumulator
// at the end of each dot product.
// Optional build macro: MAC_FEEDER_STATS_EN adds res_terms (non-bubble pairs per result).
module mac_operand_feeder
    import mac_feeder_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned MAC_LAT = 1
) (
    input  logic                 clock0,
    input  logic                 reset,
    mac_operand_feeder_if.slave  bus
);

    localparam int unsigned CNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

    feeder_state_t    r_state;
    feeder_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [OP_W-1:0]  r_mac_a;
    logic [OP_W-1:0]  r_mac_b;
    logic [OP_W-1:0]  w_mac_a_nxt;
    logic [OP_W-1:0]  w_mac_b_nxt;
    logic             r_mac_clr;
    logic             w_mac_clr_nxt;
    logic             r_res_valid;
    logic             w_res_valid_nxt;
    logic [ACC_W-1:0] r_res_data;
    logic             w_capture;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    op_pair_t         w_wdata;
    op_pair_t         w_rdata;

    assign w_push  = bus.in_valid && !w_full;
    assign w_wdata = '{last: bus.in_last, a: bus.in_a, b: bus.in_b};

    mac_feeder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock0),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state and next-output decode; MAC operands default to a zero bubble.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_mac_a_nxt     = '0;
        w_mac_b_nxt     = '0;
        w_mac_clr_nxt   = 1'b0;
        w_res_valid_nxt = r_res_valid;
        w_capture       = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) w_state_nxt = FEED;
            end
            FEED: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_mac_a_nxt = w_rdata.a;
                    w_mac_b_nxt = w_rdata.b;
                    if (w_rdata.last) begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = CNT_W'(MAC_LAT);
                    end
                end
            end
            DRAIN: begin
                // Counter reaches zero in the cycle the last product shows on mac_out.
                if (r_cnt == '0) begin
                    w_capture       = 1'b1;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (r_res_valid && bus.res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_mac_clr_nxt   = 1'b1;
                    w_state_nxt     = CLEAR;
                end
            end
            CLEAR: begin
                w_state_nxt = w_empty ? IDLE : FEED;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_clr   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mac_a     <= w_mac_a_nxt;
            r_mac_b     <= w_mac_b_nxt;
            r_mac_clr   <= w_mac_clr_nxt;
            r_res_valid <= w_res_valid_nxt;
            if (w_capture) r_res_data <= bus.mac_out;
        end
    end

`ifdef MAC_FEEDER_STATS_EN
    logic [15:0] r_terms;
    logic [15:0] r_res_terms;

    // Running pop count for the current dot product, latched alongside res_data.
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            r_terms     <= '0;
            r_res_terms <= '0;
        end else begin
            if (r_state == CLEAR)  r_terms <= '0;
            else if (w_pop)        r_terms <= sat_inc16(r_terms);
            if (w_capture)         r_res_terms <= r_terms;
        end
    end

    assign bus.res_terms = r_res_terms;
`endif

    assign bus.in_ready  = !w_full;
    assign bus.mac_a     = r_mac_a;
    assign bus.mac_b     = r_mac_b;
    assign bus.mac_clr   = r_mac_clr;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Bench for mac_operand_feeder: behavioural MAC, pair/result scoreboard, directed scenarios
// and a random dot-product sweep.
module tb_mac_operand_feeder;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned MAC_LAT = 1;

    logic clock0;
    logic reset;
    mac_operand_feeder_if bus ();

    mac_operand_feeder #(
        .DEPTH   (DEPTH),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clock0 (clock0),
        .reset  (reset),
        .bus    (bus)
    );

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int sx16(input logic [15:0] v);
        int r;
        r = $signed(v);
        return r;
    endfunction

    // Golden MAC: one edge from operands to accumulator, clear wins.
    logic [31:0] acc;
    always @(posedge clock0 or posedge reset) begin
        if (reset)            acc <= 32'd0;
        else if (bus.mac_clr) acc <= 32'd0;
        else                  acc <= acc + 32'(sx16(bus.mac_a) * sx16(bus.mac_b));
    end
    assign bus.mac_out = acc;

    // res_ready policy: 0 = held low, 1 = held high, 2 = random per cycle.
    int rdy_mode = 1;
    always @(posedge clock0) begin
        #1;
        case (rdy_mode)
            0:       bus.res_ready = 1'b0;
            1:       bus.res_ready = 1'b1;
            default: bus.res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard state.
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
        int          prod;
    } pair_t;

    pair_t       fifo_q [$];
    logic [31:0] exp_sum_q [$];
    int          exp_terms_q [$];
    logic [31:0] cur_sum;
    int          cur_terms;
    int          prod_pushed;
    int          clears_seen;
    int          results;
    int          cyc;
    int          due_cycle;
    logic        due_valid;
    logic        clr_pending;
    logic        prev_valid;
    logic [31:0] prev_data;
    logic [31:0] last_res;
    int          last_terms;

    always @(posedge clock0) cyc <= cyc + 1;

    // Compare process: every cycle, outputs against the abstract model.
    always @(negedge clock0) begin
        if (reset) begin
            fifo_q.delete();
            exp_sum_q.delete();
            exp_terms_q.delete();
            cur_sum     = 32'd0;
            cur_terms   = 0;
            prod_pushed = 0;
            clears_seen = 0;
            due_valid   = 1'b0;
            clr_pending = 1'b0;
            prev_valid  = 1'b0;
            prev_data   = 32'd0;
        end else begin
            // Any non-zero operand pair must be the oldest unfed pair.
            if (bus.mac_a != 16'd0 || bus.mac_b != 16'd0) begin
                if (fifo_q.size() == 0) begin
                    fail_bound("feed_without_push");
                end else begin
                    pair_t p;
                    p = fifo_q.pop_front();
                    chk("feed_order", {bus.mac_a, bus.mac_b}, {p.a, p.b});
                    chk("feed_after_clear", 32'(clears_seen >= p.prod), 32'd1);
                    if (p.last) begin
                        due_cycle = cyc + MAC_LAT + 1;
                        due_valid = 1'b1;
                    end
                end
            end
            chk("in_ready", 32'(bus.in_ready), 32'(fifo_q.size() < DEPTH));
            chk("mac_clr", 32'(bus.mac_clr), 32'(clr_pending));
            if (bus.mac_clr) clears_seen++;
            if (bus.res_valid && !prev_valid)
                chk("res_valid_rise", 32'(due_valid && cyc == due_cycle), 32'd1);
            if (bus.res_valid && !prev_valid) due_valid = 1'b0;
            if (bus.res_valid && prev_valid) chk("res_data_stable", bus.res_data, prev_data);
            clr_pending = bus.res_valid && bus.res_ready;
            if (bus.res_valid && bus.res_ready) begin
                if (exp_sum_q.size() == 0) begin
                    fail_bound("unexpected_result");
                end else begin
                    int et;
                    et = exp_terms_q.pop_front();
                    chk("res_data", bus.res_data, exp_sum_q.pop_front());
`ifdef MAC_FEEDER_STATS_EN
                    chk("res_terms", 32'(bus.res_terms), 32'(et));
                    last_terms = 32'(bus.res_terms);
`endif
                end
                last_res = bus.res_data;
                results++;
            end
            prev_valid = bus.res_valid;
            prev_data  = bus.res_data;
            // Record the push that the next edge will take.
            if (bus.in_valid && bus.in_ready) begin
                pair_t p;
                p.a    = bus.in_a;
                p.b    = bus.in_b;
                p.last = bus.in_last;
                p.prod = prod_pushed;
                fifo_q.push_back(p);
                cur_sum = cur_sum + 32'(sx16(bus.in_a) * sx16(bus.in_b));
                cur_terms++;
                if (bus.in_last) begin
                    exp_sum_q.push_back(cur_sum);
                    exp_terms_q.push_back(cur_terms);
                    cur_sum   = 32'd0;
                    cur_terms = 0;
                    prod_pushed++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the pair has been taken.
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        while (!bus.in_ready && n < 1000) begin
            @(posedge clock0);
            #1;
            n++;
        end
        if (!bus.in_ready) fail_bound("push_wait");
        @(posedge clock0);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock0);
            #1;
        end
    endtask

    task automatic wait_results(input int target, input int budget);
        int n = 0;
        while (results < target && n < budget) begin
            @(posedge clock0);
            #1;
            n++;
        end
        if (results < target) fail_bound("wait_results");
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clock0);
        chk({tag, "_mac_a"}, 32'(bus.mac_a), 32'd0);
        chk({tag, "_mac_b"}, 32'(bus.mac_b), 32'd0);
        chk({tag, "_mac_clr"}, 32'(bus.mac_clr), 32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_data"}, bus.res_data, 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clock0);
        #1;
    endtask

    initial begin
        int r0;
        int c0;
        int n;
        cyc          = 0;
        results      = 0;
        last_res     = 32'd0;
        last_terms   = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a     = 16'd0;
        bus.in_b     = 16'd0;
        bus.in_last  = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clock0);
        #1;
        reset = 1'b0;
        check_reset_state("por");

        // Reset in the middle of feeding with pairs still queued.
        for (int i = 0; i < 5; i++) push_pair(16'(i + 1), 16'(i + 9), 1'b0);
        #2;
        reset = 1'b1;
        @(posedge clock0);
        @(posedge clock0);
        #1;
        reset = 1'b0;
        check_reset_state("midfeed");

        // Three-term dot product: 3*4 + 5*6 + 7*8 = 98.
        r0 = results;
        c0 = clears_seen;
        push_pair(16'd3, 16'd4, 1'b0);
        push_pair(16'd5, 16'd6, 1'b0);
        push_pair(16'd7, 16'd8, 1'b1);
        wait_results(r0 + 1, 200);
        idle(3);
        chk("dot3_value", last_res, 32'd98);
        chk("dot3_clr_pulses", 32'(clears_seen - c0), 32'd1);
`ifdef MAC_FEEDER_STATS_EN
        chk("dot3_terms", 32'(last_terms), 32'd3);
`endif

        // Single-term signed product: -2 * 3.
        r0 = results;
        push_pair(16'hFFFE, 16'h0003, 1'b1);
        wait_results(r0 + 1, 200);
        chk("neg_value", last_res, 32'hFFFF_FFFA);
`ifdef MAC_FEEDER_STATS_EN
        chk("single_terms", 32'(last_terms), 32'd1);
`endif

        // Bubbles between terms leave the sum unchanged.
        r0 = results;
        push_pair(16'd3, 16'd4, 1'b0);
        push_pair(16'd5, 16'd6, 1'b0);
        idle(4);
        push_pair(16'd7, 16'd8, 1'b1);
        wait_results(r0 + 1, 200);
        chk("gap_value", last_res, 32'd98);

        // Fill while a result is held: FIFO takes exactly DEPTH pairs.
        r0 = results;
        rdy_mode = 0;
        idle(1);
        push_pair(16'd1, 16'd1, 1'b1);
        n = 0;
        while (!bus.res_valid && n < 50) begin
            idle(1);
            n++;
        end
        if (!bus.res_valid) fail_bound("fill_hold");
        for (int i = 0; i < DEPTH; i++) push_pair(16'(i + 1), 16'(i + 2), 1'b0);
        idle(1);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        rdy_mode = 1;
        push_pair(16'(DEPTH + 1), 16'(DEPTH + 2), 1'b0);
        push_pair(16'(DEPTH + 2), 16'(DEPTH + 3), 1'b1);
        wait_results(r0 + 2, 300);
        // Sum of (i+1)*(i+2) for i = 0..9.
        chk("fill_value", last_res, 32'd440);

        // Random dot products, 1-16 terms, random consumer backpressure.
        r0 = results;
        rdy_mode = 2;
        for (int p = 0; p < 1000; p++) begin
            int terms;
            terms = $urandom_range(1, 16);
            for (int t = 0; t < terms; t++) begin
                push_pair(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)),
                          1'(t == terms - 1));
                if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
            end
        end
        wait_results(r0 + 1000, 5000);
        chk("random_count", 32'(results - r0), 32'd1000);
        rdy_mode = 1;
        idle(5);
        chk("queues_drained", 32'(fifo_q.size() + exp_sum_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
